alpu_slice_sched: RTL and testbench

- Shares one REG_WIDTH-bit ALPU between NUM_REQ requesters using round-robin arbitration.
- Executes each granted wide operation (REG_WIDTH*NUM_SLICES bits) as a sequence of REG_WIDTH-bit slices, LSB slice first.
- Chains the carry from each slice into the next.
- Sits between the issue logic and the ALPU. It drives the ALPU's a/b/instr/cin inputs and captures out/cout.

---
 rtl/alpu_pkg.sv | 16 +
 rtl/alpu_slice_sched_rr_arbiter.sv | 28 ++
 rtl/alpu_slice_sched.sv | 121 ++++++++++++
 tb/tb_alpu_slice_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpu_pkg.sv
// Shared types and constants for the sliced ALPU scheduler.
// The instruction encodings match the bench ALPU model; the scheduler treats instructions as opaque.
package alpu_pkg;

  localparam int ALPU_INSTR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

  localparam logic [ALPU_INSTR_W-1:0] INSTR_ADD = 4'h0;
  localparam logic [ALPU_INSTR_W-1:0] INSTR_AND = 4'h1;

endpackage

// File: rtl/alpu_slice_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Requester ptr has the highest priority, then ptr+1, and so on, wrapping around.
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alpu_slice_sched.sv
// Shares one narrow ALPU between several requesters: arbitrates round-robin,
// then runs each wide operation as LSB-first slices with the carry chained between slices.
module alpu_slice_sched
  import alpu_pkg::*;
#(
  parameter int REG_WIDTH  = 4,
  parameter int NUM_SLICES = 4,
  parameter int NUM_REQ    = 2,
  localparam int OP_W  = REG_WIDTH * NUM_SLICES,
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0]          req_a_i,
  input  logic [NUM_REQ*OP_W-1:0]          req_b_i,
  input  logic [NUM_REQ*ALPU_INSTR_W-1:0]  req_instr_i,
  input  logic [NUM_REQ-1:0]               req_cin_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [ID_W-1:0]                  rsp_id_o,
  output logic [OP_W-1:0]                  rsp_out_o,
  output logic                             rsp_cout_o,
  output logic [REG_WIDTH-1:0]             alpu_a_o,
  output logic [REG_WIDTH-1:0]             alpu_b_o,
  output logic [ALPU_INSTR_W-1:0]          alpu_instr_o,
  output logic                             alpu_cin_o,
  input  logic [REG_WIDTH-1:0]             alpu_out_i,
  input  logic                             alpu_cout_i
);

  sched_state_t              state_q, state_d;
  logic [ID_W-1:0]           rr_ptr_q, id_q, grant_id;
  logic [CNT_W-1:0]          slice_q;
  logic [OP_W-1:0]           a_q, b_q, res_q;
  logic [ALPU_INSTR_W-1:0]   instr_q;
  logic                      carry_q;
  logic [NUM_REQ-1:0]        arb_req, grant;
  logic                      req_fire, last_slice;

  assign arb_req = (state_q == IDLE) ? req_valid_i : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign req_ready_o = grant;
  assign req_fire    = |grant;
  assign last_slice  = (slice_q == CNT_W'(NUM_SLICES - 1));

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_fire)    state_d = EXEC;
      EXEC:    if (last_slice)  state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // carry_q holds the request cin for slice 0 and each slice's cout afterwards.
  assign alpu_a_o     = (state_q == EXEC) ? a_q[REG_WIDTH-1:0] : '0;
  assign alpu_b_o     = (state_q == EXEC) ? b_q[REG_WIDTH-1:0] : '0;
  assign alpu_instr_o = (state_q == EXEC) ? instr_q : '0;
  assign alpu_cin_o   = (state_q == EXEC) ? carry_q : 1'b0;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = id_q;
  assign rsp_out_o   = res_q;
  assign rsp_cout_o  = carry_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      slice_q  <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      instr_q  <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            a_q      <= req_a_i[grant_id*OP_W +: OP_W];
            b_q      <= req_b_i[grant_id*OP_W +: OP_W];
            instr_q  <= req_instr_i[grant_id*ALPU_INSTR_W +: ALPU_INSTR_W];
            carry_q  <= req_cin_i[grant_id];
            id_q     <= grant_id;
            slice_q  <= '0;
            rr_ptr_q <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
          end
        end
        EXEC: begin
          // Operands shift down one slice per cycle; results shift in from the top.
          a_q     <= a_q >> REG_WIDTH;
          b_q     <= b_q >> REG_WIDTH;
          res_q   <= OP_W'({alpu_out_i, res_q} >> REG_WIDTH);
          carry_q <= alpu_cout_i;
          slice_q <= last_slice ? '0 : slice_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alpu_slice_sched.sv
// Self-checking bench for alpu_slice_sched with a behavioural 4-bit ALPU model.
// Table-driven single-requester operations plus directed arbitration, stall, reset and operand-hold sequences.
module tb_alpu_slice_sched;
  import alpu_pkg::*;

  localparam int RW  = 4;
  localparam int NS  = 4;
  localparam int NR  = 2;
  localparam int OPW = RW * NS;

  logic            clk;
  logic            reset_n;
  logic [NR-1:0]   req_valid_i;
  logic [NR-1:0]   req_ready_o;
  logic [NR*OPW-1:0] req_a_i, req_b_i;
  logic [NR*4-1:0] req_instr_i;
  logic [NR-1:0]   req_cin_i;
  logic            rsp_valid_o, rsp_ready_i;
  logic [0:0]      rsp_id_o;
  logic [OPW-1:0]  rsp_out_o;
  logic            rsp_cout_o;
  logic [RW-1:0]   alpu_a_o, alpu_b_o, alpu_out_i;
  logic [3:0]      alpu_instr_o;
  logic            alpu_cin_o, alpu_cout_i;
  logic [4:0]      alpu_sum;

  alpu_slice_sched #(.REG_WIDTH(RW), .NUM_SLICES(NS), .NUM_REQ(NR)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_instr_i  (req_instr_i),
    .req_cin_i    (req_cin_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_out_o    (rsp_out_o),
    .rsp_cout_o   (rsp_cout_o),
    .alpu_a_o     (alpu_a_o),
    .alpu_b_o     (alpu_b_o),
    .alpu_instr_o (alpu_instr_o),
    .alpu_cin_o   (alpu_cin_o),
    .alpu_out_i   (alpu_out_i),
    .alpu_cout_i  (alpu_cout_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALPU model: ADD with carry, AND with zero carry-out.
  always_comb begin
    alpu_sum    = '0;
    alpu_out_i  = '0;
    alpu_cout_i = 1'b0;
    case (alpu_instr_o)
      INSTR_ADD: begin
        alpu_sum    = {1'b0, alpu_a_o} + {1'b0, alpu_b_o} + {4'b0, alpu_cin_o};
        alpu_out_i  = alpu_sum[3:0];
        alpu_cout_i = alpu_sum[4];
      end
      INSTR_AND: alpu_out_i = alpu_a_o & alpu_b_o;
      default: ;
    endcase
  end

  typedef struct {
    int         sel;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  instr;
    logic        cin;
    logic [15:0] exp_out;
    logic        exp_cout;
    logic [3:0]  exp_cin_seq;
  } vec_t;

  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] instr, input logic cin);
    req_a_i[sel*OPW +: OPW]   = a;
    req_b_i[sel*OPW +: OPW]   = b;
    req_instr_i[sel*4 +: 4]   = instr;
    req_cin_i[sel]            = cin;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " rsp_valid"}, rsp_valid_o, 0);
    checkOutput({tag, " rsp_id"}, rsp_id_o, 0);
    checkOutput({tag, " rsp_out"}, rsp_out_o, 0);
    checkOutput({tag, " rsp_cout"}, rsp_cout_o, 0);
    checkOutput({tag, " req_ready"}, req_ready_o, 0);
    checkOutput({tag, " alpu_a"}, alpu_a_o, 0);
    checkOutput({tag, " alpu_b"}, alpu_b_o, 0);
    checkOutput({tag, " alpu_instr"}, alpu_instr_o, 0);
    checkOutput({tag, " alpu_cin"}, alpu_cin_o, 0);
  endtask

  task automatic runVector(input vec_t v, input int n);
    logic [15:0] av, bv;
    av = v.a;
    bv = v.b;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    applyStimulus(v.sel, v.a, v.b, v.instr, v.cin);
    req_valid_i[v.sel] = 1'b1;
    #1;
    checkOutput($sformatf("v%0d req_ready", n), req_ready_o, 32'(1 << v.sel));
    tick;
    req_valid_i = '0;
    for (int k = 0; k < NS; k++) begin
      checkOutput($sformatf("v%0d s%0d alpu_a", n, k), alpu_a_o, av[k*4 +: 4]);
      checkOutput($sformatf("v%0d s%0d alpu_b", n, k), alpu_b_o, bv[k*4 +: 4]);
      checkOutput($sformatf("v%0d s%0d alpu_instr", n, k), alpu_instr_o, v.instr);
      checkOutput($sformatf("v%0d s%0d alpu_cin", n, k), alpu_cin_o, v.exp_cin_seq[k]);
      checkOutput($sformatf("v%0d s%0d rsp_valid", n, k), rsp_valid_o, 0);
      tick;
    end
    checkOutput($sformatf("v%0d rsp_valid", n), rsp_valid_o, 1);
    checkOutput($sformatf("v%0d rsp_out", n), rsp_out_o, v.exp_out);
    checkOutput($sformatf("v%0d rsp_cout", n), rsp_cout_o, v.exp_cout);
    checkOutput($sformatf("v%0d rsp_id", n), rsp_id_o, v.sel);
    rsp_ready_i = 1'b1;
    tick;
    rsp_ready_i = 1'b0;
    checkOutput($sformatf("v%0d rsp_valid after accept", n), rsp_valid_o, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 16'h00FF, 16'h0001, INSTR_ADD, 1'b0, 16'h0100, 1'b0, 4'b0110};
    vecs[1] = '{1, 16'hFFFF, 16'h0001, INSTR_ADD, 1'b0, 16'h0000, 1'b1, 4'b1110};
    vecs[2] = '{0, 16'h8888, 16'h8888, INSTR_ADD, 1'b0, 16'h1110, 1'b1, 4'b1110};
    vecs[3] = '{1, 16'h1234, 16'h4321, INSTR_ADD, 1'b1, 16'h5556, 1'b0, 4'b0001};
    vecs[4] = '{0, 16'h1234, 16'h0F0F, INSTR_AND, 1'b0, 16'h0204, 1'b0, 4'b0000};

    reset_n     = 1'b0;
    req_valid_i = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    req_instr_i = '0;
    req_cin_i   = '0;
    rsp_ready_i = 1'b0;
    tick;
    tick;
    reset_n = 1'b1;
    checkAllZero("reset");

    for (int n = 0; n < 5; n++) runVector(vecs[n], n);

    // Both requesters valid continuously: grants must alternate starting at 0.
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    applyStimulus(0, 16'h0001, 16'h0001, INSTR_ADD, 1'b0);
    applyStimulus(1, 16'h0010, 16'h0010, INSTR_ADD, 1'b0);
    req_valid_i = 2'b11;
    rsp_ready_i = 1'b1;
    for (int op = 0; op < 4; op++) begin
      #1;
      checkOutput($sformatf("rr op%0d grant", op), req_ready_o, (op % 2 == 0) ? 2'b01 : 2'b10);
      checkOutput($sformatf("rr op%0d onehot", op), ($countones(req_ready_o) <= 1), 1);
      tick;
      for (int k = 0; k < NS; k++) begin
        checkOutput($sformatf("rr op%0d s%0d ready", op, k), req_ready_o, 0);
        tick;
      end
      checkOutput($sformatf("rr op%0d rsp_valid", op), rsp_valid_o, 1);
      checkOutput($sformatf("rr op%0d rsp_id", op), rsp_id_o, op % 2);
      checkOutput($sformatf("rr op%0d rsp_out", op), rsp_out_o, (op % 2 == 0) ? 16'h0002 : 16'h0020);
      tick;
    end

    // Response stall: outputs must hold while rsp_ready_i is low.
    rsp_ready_i = 1'b0;
    applyStimulus(0, 16'h00FF, 16'h0001, INSTR_ADD, 1'b0);
    req_valid_i = 2'b01;
    #1;
    checkOutput("stall grant", req_ready_o, 2'b01);
    tick;
    req_valid_i = 2'b11;
    for (int k = 0; k < NS; k++) tick;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("stall c%0d rsp_valid", c), rsp_valid_o, 1);
      checkOutput($sformatf("stall c%0d rsp_out", c), rsp_out_o, 16'h0100);
      checkOutput($sformatf("stall c%0d rsp_cout", c), rsp_cout_o, 0);
      checkOutput($sformatf("stall c%0d rsp_id", c), rsp_id_o, 0);
      checkOutput($sformatf("stall c%0d req_ready", c), req_ready_o, 0);
      if (c < 3) tick;
    end
    rsp_ready_i = 1'b1;
    tick;
    rsp_ready_i = 1'b0;
    checkOutput("stall idle rsp_valid", rsp_valid_o, 0);
    checkOutput("stall idle grant", req_ready_o, 2'b10);

    // Reset during slice 2 aborts the operation and returns rr_ptr to 0.
    req_valid_i = 2'b01;
    #1;
    checkOutput("abort grant", req_ready_o, 2'b01);
    tick;
    req_valid_i = '0;
    tick;
    tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    checkAllZero("abort");
    tick;
    checkOutput("abort no rsp later", rsp_valid_o, 0);
    req_valid_i = 2'b11;
    #1;
    checkOutput("abort rr_ptr zero", req_ready_o, 2'b01);
    req_valid_i = 2'b10;
    #1;
    checkOutput("abort req1 accept", req_ready_o, 2'b10);
    tick;
    req_valid_i = '0;
    for (int k = 0; k < NS; k++) tick;
    checkOutput("abort req1 rsp_valid", rsp_valid_o, 1);
    checkOutput("abort req1 rsp_id", rsp_id_o, 1);
    checkOutput("abort req1 rsp_out", rsp_out_o, 16'h0020);
    rsp_ready_i = 1'b1;
    tick;
    rsp_ready_i = 1'b0;

    // Operands scrambled during EXEC must not affect the result.
    applyStimulus(0, 16'hF0F0, 16'hFF00, INSTR_AND, 1'b1);
    req_valid_i = 2'b01;
    #1;
    checkOutput("hold grant", req_ready_o, 2'b01);
    tick;
    req_valid_i = '0;
    for (int k = 0; k < NS; k++) begin
      req_a_i[15:0] = 16'($urandom);
      req_b_i[15:0] = 16'($urandom);
      req_instr_i[3:0] = INSTR_ADD;
      #1;
      checkOutput($sformatf("hold s%0d alpu_cin", k), alpu_cin_o, (k == 0) ? 1 : 0);
      tick;
    end
    checkOutput("hold rsp_valid", rsp_valid_o, 1);
    checkOutput("hold rsp_out", rsp_out_o, 16'hF000);
    checkOutput("hold rsp_id", rsp_id_o, 0);
    rsp_ready_i = 1'b1;
    tick;
    rsp_ready_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
